// File: rtl/pc_steering_controller_if.sv
// Bundle of PC-stage inputs and steering outputs exchanged with pc_steering_controller.
// master = PC/execute stage side, slave = steering controller.
interface pc_steering_controller_if;
  logic [31:0] PC;
  logic        STALL_EXECUTION_STAGE;
  logic [4:0]  ALU_INSTRUCTION;
  logic        BRANCH_VALID;
  logic        BRANCH_TAKEN;
  logic [31:0] PC_EXECUTION;
  logic [31:0] RS1_DATA;
  logic [31:0] IMM_INPUT;
  logic [31:0] PREDICTED_PC;
  logic        PC_PREDICT_SELECT;
  logic        PC_MISPREDICT_SELECT;
  logic [31:0] REDIRECT_PC;
  logic        CLEAR_DECODING_STAGE;
  logic        CLEAR_EXECUTION_STAGE;
  logic        BTB_READY;

  modport master (
    output PC, STALL_EXECUTION_STAGE, ALU_INSTRUCTION, BRANCH_VALID, BRANCH_TAKEN,
           PC_EXECUTION, RS1_DATA, IMM_INPUT,
    input  PREDICTED_PC, PC_PREDICT_SELECT, PC_MISPREDICT_SELECT, REDIRECT_PC,
           CLEAR_DECODING_STAGE, CLEAR_EXECUTION_STAGE, BTB_READY
  );

  modport slave (
    input  PC, STALL_EXECUTION_STAGE, ALU_INSTRUCTION, BRANCH_VALID, BRANCH_TAKEN,
           PC_EXECUTION, RS1_DATA, IMM_INPUT,
    output PREDICTED_PC, PC_PREDICT_SELECT, PC_MISPREDICT_SELECT, REDIRECT_PC,
           CLEAR_DECODING_STAGE, CLEAR_EXECUTION_STAGE, BTB_READY
  );
endinterface

// File: rtl/pc_steering_controller.sv
// PC steering: direct-mapped BTB prediction at fetch, branch/JAL/JALR resolution at
// execute with same-cycle redirect, two-stage flush and BTB training.
module pc_steering_controller #(
  parameter int         ENTRIES  = 16,
  parameter logic [4:0] ALU_JAL  = 5'b01010,
  parameter logic [4:0] ALU_JALR = 5'b01011
) (
  input logic CLK,
  input logic RST_N,
  pc_steering_controller_if.slave bus
);
  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDX;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t             state_r;
  logic [IDX-1:0]     sweep_idx_r;

  logic               btb_valid_r  [ENTRIES];
  logic [TAGW-1:0]    btb_tag_r    [ENTRIES];
  logic [31:0]        btb_target_r [ENTRIES];
  logic [1:0]         btb_ctr_r    [ENTRIES];

  logic               dec_valid_r, dec_pred_taken_r;
  logic [31:0]        dec_pred_target_r;
  logic               ex_valid_r, ex_pred_taken_r;
  logic [31:0]        ex_pred_target_r;

  logic [IDX-1:0]     fetch_idx_s, exec_idx_s;
  logic [TAGW-1:0]    fetch_tag_s, exec_tag_s;
  logic               fetch_hit_s, exec_hit_s;
  logic               is_jalr_s, ctrl_s, actual_taken_s;
  logic [31:0]        taken_target_s, fallthrough_s;
  logic               resolve_s, mispredict_s, train_s, predict_sel_s;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    ctr_inc = (c == 2'd3) ? 2'd3 : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    ctr_dec = (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  // BTB lookups: fetch port for prediction, execute port for training
  always_comb begin
    fetch_idx_s = bus.PC[IDX+1:2];
    fetch_tag_s = bus.PC[31:IDX+2];
    exec_idx_s  = bus.PC_EXECUTION[IDX+1:2];
    exec_tag_s  = bus.PC_EXECUTION[31:IDX+2];
    fetch_hit_s = btb_valid_r[fetch_idx_s] && (btb_tag_r[fetch_idx_s] == fetch_tag_s);
    exec_hit_s  = btb_valid_r[exec_idx_s] && (btb_tag_r[exec_idx_s] == exec_tag_s);
  end

  // Execute-stage resolution; a non-control instruction predicted taken resolves as not-taken
  always_comb begin
    is_jalr_s      = 1'b0;
    ctrl_s         = 1'b0;
    actual_taken_s = 1'b0;
    fallthrough_s  = bus.PC_EXECUTION + 32'd4;
    taken_target_s = bus.PC_EXECUTION + bus.IMM_INPUT;
    if (bus.BRANCH_VALID) begin
      ctrl_s         = 1'b1;
      actual_taken_s = bus.BRANCH_TAKEN;
    end else if (bus.ALU_INSTRUCTION == ALU_JAL) begin
      ctrl_s         = 1'b1;
      actual_taken_s = 1'b1;
    end else if (bus.ALU_INSTRUCTION == ALU_JALR) begin
      is_jalr_s      = 1'b1;
      ctrl_s         = 1'b1;
      actual_taken_s = 1'b1;
    end else begin
      ctrl_s         = 1'b0;
    end
    if (is_jalr_s) begin
      taken_target_s = (bus.RS1_DATA + bus.IMM_INPUT) & 32'hFFFF_FFFE;
    end else begin
      taken_target_s = bus.PC_EXECUTION + bus.IMM_INPUT;
    end
    resolve_s     = (state_r == ST_RUN) && ex_valid_r && !bus.STALL_EXECUTION_STAGE;
    mispredict_s  = resolve_s && ((ex_pred_taken_r != actual_taken_s) ||
                    (actual_taken_s && (ex_pred_target_r != taken_target_s)));
    train_s       = resolve_s && (ctrl_s || ex_pred_taken_r);
    predict_sel_s = (state_r == ST_RUN) && fetch_hit_s && btb_ctr_r[fetch_idx_s][1] &&
                    !mispredict_s && !bus.STALL_EXECUTION_STAGE;
  end

  assign bus.PREDICTED_PC          = btb_target_r[fetch_idx_s];
  assign bus.PC_PREDICT_SELECT     = predict_sel_s;
  assign bus.PC_MISPREDICT_SELECT  = mispredict_s;
  assign bus.REDIRECT_PC           = (mispredict_s && actual_taken_s) ? taken_target_s : fallthrough_s;
  assign bus.CLEAR_DECODING_STAGE  = mispredict_s;
  assign bus.CLEAR_EXECUTION_STAGE = mispredict_s;
  assign bus.BTB_READY             = (state_r == ST_RUN);

  // Init sweep walks every index once, then hands over to normal operation
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r     <= ST_INIT;
      sweep_idx_r <= '0;
    end else begin
      case (state_r)
        ST_INIT: begin
          if (sweep_idx_r == IDX'(ENTRIES - 1)) begin
            state_r <= ST_RUN;
          end else begin
            sweep_idx_r <= sweep_idx_r + IDX'(1);
          end
        end
        ST_RUN:  state_r <= ST_RUN;
        default: state_r <= ST_INIT;
      endcase
    end
  end

  // BTB storage: sweep clear during init, training on resolved control transfers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid_r[i]  <= 1'b0;
        btb_tag_r[i]    <= '0;
        btb_target_r[i] <= 32'd0;
        btb_ctr_r[i]    <= 2'd0;
      end
    end else if (state_r == ST_INIT) begin
      btb_valid_r[sweep_idx_r] <= 1'b0;
      btb_ctr_r[sweep_idx_r]   <= 2'd0;
    end else if (train_s) begin
      if (exec_hit_s) begin
        if (actual_taken_s) begin
          btb_ctr_r[exec_idx_s]    <= ctr_inc(btb_ctr_r[exec_idx_s]);
          btb_target_r[exec_idx_s] <= taken_target_s;
        end else begin
          btb_ctr_r[exec_idx_s]    <= ctr_dec(btb_ctr_r[exec_idx_s]);
        end
      end else if (actual_taken_s) begin
        btb_valid_r[exec_idx_s]  <= 1'b1;
        btb_tag_r[exec_idx_s]    <= exec_tag_s;
        btb_target_r[exec_idx_s] <= taken_target_s;
        btb_ctr_r[exec_idx_s]    <= 2'd2;
      end else begin
        btb_ctr_r[exec_idx_s]    <= btb_ctr_r[exec_idx_s];
      end
    end else begin
      btb_ctr_r[exec_idx_s] <= btb_ctr_r[exec_idx_s];
    end
  end

  // Prediction tracking pipe: fetch -> decode -> execute, holds on stall, bubbles on flush
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dec_valid_r       <= 1'b0;
      dec_pred_taken_r  <= 1'b0;
      dec_pred_target_r <= 32'd0;
      ex_valid_r        <= 1'b0;
      ex_pred_taken_r   <= 1'b0;
      ex_pred_target_r  <= 32'd0;
    end else if (bus.STALL_EXECUTION_STAGE) begin
      dec_valid_r <= dec_valid_r;
      ex_valid_r  <= ex_valid_r;
    end else if (mispredict_s) begin
      dec_valid_r      <= 1'b0;
      dec_pred_taken_r <= 1'b0;
      ex_valid_r       <= 1'b0;
      ex_pred_taken_r  <= 1'b0;
    end else begin
      ex_valid_r        <= dec_valid_r;
      ex_pred_taken_r   <= dec_pred_taken_r;
      ex_pred_target_r  <= dec_pred_target_r;
      dec_valid_r       <= 1'b1;
      dec_pred_taken_r  <= predict_sel_s;
      dec_pred_target_r <= btb_target_r[fetch_idx_s];
    end
  end
endmodule

// File: tb/tb_pc_steering_controller.sv
// Directed bench for pc_steering_controller: expected outputs are queued per step
// and compared on the falling edge, between the rising edges that drive and update.
module tb_pc_steering_controller;
  localparam logic [4:0] ALU_JAL  = 5'b01010;
  localparam logic [4:0] ALU_JALR = 5'b01011;

  logic CLK;
  logic RST_N;
  pc_steering_controller_if bus();

  pc_steering_controller #(.ENTRIES(16), .ALU_JAL(ALU_JAL), .ALU_JALR(ALU_JALR)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        ready, psel, msel, clr;
    logic [31:0] redirect;
    logic        chk_pred;
    logic [31:0] pred;
  } exp_t;

  exp_t exp_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   step_no  = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    chk_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s step %0d: observed %h expected %h", name, step_no, obs, expv);
  endtask

  function automatic exp_t mk(input logic r, input logic p, input logic m, input logic c,
                              input logic [31:0] rd, input logic cp, input logic [31:0] pd);
    exp_t e;
    e.ready = r; e.psel = p; e.msel = m; e.clr = c;
    e.redirect = rd; e.chk_pred = cp; e.pred = pd;
    return e;
  endfunction

  task automatic drv(input logic [31:0] pc, input logic stall, input logic [4:0] alu,
                     input logic bv, input logic bt, input logic [31:0] pce,
                     input logic [31:0] rs1, input logic [31:0] imm);
    bus.PC = pc; bus.STALL_EXECUTION_STAGE = stall; bus.ALU_INSTRUCTION = alu;
    bus.BRANCH_VALID = bv; bus.BRANCH_TAKEN = bt; bus.PC_EXECUTION = pce;
    bus.RS1_DATA = rs1; bus.IMM_INPUT = imm;
  endtask

  task automatic idle(input logic [31:0] pc);
    drv(pc, 1'b0, 5'd0, 1'b0, 1'b0, 32'h3000, 32'd0, 32'd0);
  endtask

  task automatic cyc(input exp_t e);
    exp_t x;
    exp_q.push_back(e);
    @(negedge CLK);
    x = exp_q.pop_front();
    chk("btb_ready",   {31'd0, bus.BTB_READY},             {31'd0, x.ready});
    chk("predict_sel", {31'd0, bus.PC_PREDICT_SELECT},     {31'd0, x.psel});
    chk("mispred_sel", {31'd0, bus.PC_MISPREDICT_SELECT},  {31'd0, x.msel});
    chk("clear_dec",   {31'd0, bus.CLEAR_DECODING_STAGE},  {31'd0, x.clr});
    chk("clear_ex",    {31'd0, bus.CLEAR_EXECUTION_STAGE}, {31'd0, x.clr});
    chk("redirect_pc", bus.REDIRECT_PC, x.redirect);
    if (x.chk_pred) chk("predicted_pc", bus.PREDICTED_PC, x.pred);
    @(posedge CLK);
    #1;
    step_no++;
  endtask

  initial begin
    RST_N = 1'b0;
    drv(32'h100, 1'b0, 5'd0, 1'b1, 1'b1, 32'h100, 32'd0, 32'h40);
    // reset: branch inputs present but nothing may steer
    cyc(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h104, 1'b1, 32'h0));
    cyc(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h104, 1'b1, 32'h0));
    RST_N = 1'b1;
    for (int i = 0; i < 16; i++)
      cyc(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h104, 1'b1, 32'h0));
    idle(32'h8000);
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h3004, 1'b0, 32'h0));

    // cold taken branch at 0x100 -> redirect 0x140, allocate ctr=2
    drv(32'h8000, 1'b0, 5'd0, 1'b1, 1'b1, 32'h100, 32'd0, 32'h40);
    cyc(mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h140, 1'b0, 32'h0));
    drv(32'h100, 1'b0, 5'd0, 1'b1, 1'b1, 32'h100, 32'd0, 32'h40);
    cyc(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h104, 1'b1, 32'h140));
    drv(32'h8000, 1'b0, 5'd0, 1'b1, 1'b1, 32'h100, 32'd0, 32'h40);
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h104, 1'b0, 32'h0));
    // predicted branch resolves not-taken; same-cycle hit at fetch loses to redirect
    drv(32'h100, 1'b0, 5'd0, 1'b1, 1'b0, 32'h100, 32'd0, 32'h40);
    cyc(mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h104, 1'b1, 32'h140));
    idle(32'h100);
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h3004, 1'b1, 32'h140));
    idle(32'h8000);
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h3004, 1'b0, 32'h0));

    // JALR cold -> 0x2010, then a predicted repeat -> no redirect
    drv(32'h8000, 1'b0, ALU_JALR, 1'b0, 1'b0, 32'h488, 32'h2001, 32'h10);
    cyc(mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h2010, 1'b0, 32'h0));
    idle(32'h488);
    cyc(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h3004, 1'b1, 32'h2010));
    idle(32'h8000);
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h3004, 1'b0, 32'h0));
    drv(32'h8000, 1'b0, ALU_JALR, 1'b0, 1'b0, 32'h488, 32'h2001, 32'h10);
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h48C, 1'b0, 32'h0));

    // stalled mispredicting branch: silent for 3 cycles, redirect once released
    for (int i = 0; i < 3; i++) begin
      drv(32'h488, 1'b1, 5'd0, 1'b1, 1'b1, 32'h50C, 32'd0, 32'h20);
      cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h510, 1'b1, 32'h2010));
    end
    drv(32'h488, 1'b0, 5'd0, 1'b1, 1'b1, 32'h50C, 32'd0, 32'h20);
    cyc(mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h52C, 1'b1, 32'h2010));
    idle(32'h8000);
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h3004, 1'b0, 32'h0));
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h3004, 1'b0, 32'h0));

    // alias: train 0x200, fetch it predicted, then resolve it as a plain ALU op
    drv(32'h8000, 1'b0, 5'd0, 1'b1, 1'b1, 32'h200, 32'd0, 32'h40);
    cyc(mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h240, 1'b0, 32'h0));
    idle(32'h200);
    cyc(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h3004, 1'b1, 32'h240));
    idle(32'h8000);
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h3004, 1'b0, 32'h0));
    drv(32'h8000, 1'b0, 5'd0, 1'b0, 1'b0, 32'h200, 32'd0, 32'd0);
    cyc(mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h204, 1'b0, 32'h0));
    idle(32'h200);
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h3004, 1'b1, 32'h240));
    idle(32'h8000);
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h3004, 1'b0, 32'h0));

    // JAL whose target wraps past 2^32
    drv(32'h8000, 1'b0, ALU_JAL, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'd0, 32'h20);
    cyc(mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 32'h0));

    // reset mid-run: immediate return to init, BTB contents gone
    RST_N = 1'b0;
    idle(32'h488);
    cyc(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h3004, 1'b1, 32'h0));
    RST_N = 1'b1;
    for (int i = 0; i < 16; i++)
      cyc(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h3004, 1'b1, 32'h0));
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h3004, 1'b1, 32'h0));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
